// File: rtl/store_unit.sv
// RV32I store path: turns sb/sh/sw into word-wide memory writes, using
// read-modify-write for sub-word stores since the memory has no byte enables.
module store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [2:0]  dm_select,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        st_ready,
  output logic        stall,
  output logic        st_done,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [2:0] SEL_SB = 3'b000;
  localparam logic [2:0] SEL_SH = 3'b001;
  localparam logic [2:0] SEL_SW = 3'b010;

  state_t      state, state_nxt;
  logic [2:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged;
  logic        req_take;
  logic        req_bad;
  logic        req_ok;

  always_comb begin
    // NOTE: give every always_comb target a default first so no path infers a latch.
    req_bad = 1'b0;
    case (dm_select)
      SEL_SB:  req_bad = 1'b0;
      SEL_SH:  req_bad = addr[0];
      SEL_SW:  req_bad = |addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  assign req_take = st_valid && st_ready;
  assign req_ok   = req_take && !req_bad;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_ok) state_nxt = (dm_select == SEL_SW) ? WRITE : READ;
      READ:    if (mem_ack) state_nxt = WRITE;
      WRITE:   if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; mem_req decodes the state so an async reset drops it at once.
  always_comb begin
    mem_req  = (state != IDLE);
    mem_we   = (state == WRITE);
    st_ready = (state == IDLE);
    stall    = (state != IDLE);
  end

  // The accepted store data sits in the write register; the read ack splices
  // its low byte/half into the fetched word at the addressed lane.
  always_comb begin
    merged = mem_rdata;
    case (sel_q)
      SEL_SB:  merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SEL_SH:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= SEL_SB;
      addr_q     <= '0;
      wdata_q    <= '0;
      st_done    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      st_done    <= (state == WRITE) && mem_ack;
      misaligned <= req_take && req_bad;
      if (req_ok) begin
        sel_q   <= dm_select;
        addr_q  <= addr;
        wdata_q <= store_data;
      end
      if (state == READ && mem_ack) wdata_q <= merged;
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: a byte-lane reference model and a
// word memory with configurable wait states drive directed and random stores.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [2:0]  dm_select;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        st_ready;
  logic        stall;
  logic        st_done;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .dm_select  (dm_select),
    .addr       (addr),
    .store_data (store_data),
    .st_ready   (st_ready),
    .stall      (stall),
    .st_done    (st_done),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] mem_words [bit [29:0]];
  int          wait_cycles = 0;
  bit          spurious = 1'b0;
  int          resp_waited = 0;
  int          unstable = 0;
  bit          lg_in = 1'b0;
  bit          lg_we;
  logic [31:0] lg_addr;
  logic [31:0] lg_wdata;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    bit [29:0] idx = a[31:2];
    if (mem_words.exists(idx)) return mem_words[idx];
    return ({2'b00, idx} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference: a store of 2**sel bytes lands at byte offset addr[1:0] of the word.
  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [2:0] sel,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r = old;
    int size = 1 << int'(sel);
    int off  = int'(a[1:0]);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + size) r[8*b +: 8] = d[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic bit model_reject(input logic [2:0] sel, input logic [31:0] a);
    if (sel > 3'd2) return 1'b1;
    return (int'(a[1:0]) % (1 << int'(sel))) != 0;
  endfunction

  // Memory responder: decides ack for each cycle just after the rising edge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (resp_waited >= wait_cycles) begin
          mem_ack     = 1'b1;
          mem_rdata   = mem_peek(mem_addr);
          resp_waited = 0;
        end else begin
          mem_ack     = 1'b0;
          mem_rdata   = $urandom;
          resp_waited++;
        end
      end else begin
        mem_ack     = spurious;
        mem_rdata   = $urandom;
        resp_waited = 0;
      end
    end
  end

  // Access logger: records every completed access and tracks bus stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (!lg_in) begin
          lg_in    = 1'b1;
          lg_we    = mem_we;
          lg_addr  = mem_addr;
          lg_wdata = mem_wdata;
        end else if (mem_addr !== lg_addr || mem_we !== lg_we || (mem_we && mem_wdata !== lg_wdata)) begin
          unstable++;
        end
        if (mem_ack) begin
          acc_q.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) mem_words[mem_addr[31:2]] = mem_wdata;
          lg_in = 1'b0;
        end
      end else begin
        lg_in = 1'b0;
      end
    end
  end

  task automatic present(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
    st_valid   = 1'b1;
    dm_select  = sel;
    addr       = a;
    store_data = d;
  endtask

  task automatic idle_inputs();
    st_valid   = 1'b0;
    dm_select  = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
  endtask

  // Issues one legal store at the current falling edge and checks it end to end.
  task automatic store_scenario(input string name, input logic [2:0] sel, input logic [31:0] a,
                                input logic [31:0] d, input int waits);
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    int          exp_lat;
    int          lat;
    bit          gap;
    bit          sub;
    sub      = (sel != 3'b010);
    exp_addr = {a[31:2], 2'b00};
    exp_word = model_merge(mem_peek(a), sel, a, d);
    exp_lat  = sub ? 3 + 2 * waits : 2 + waits;
    wait_cycles = waits;
    acc_q.delete();
    n_checks++;
    if (st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_at_accept: got %b expected 1", name, st_ready);
    end
    present(sel, a, d);
    @(negedge clk);
    idle_inputs();
    lat = -1;
    gap = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (st_done === 1'b1) begin
        lat = c;
        break;
      end
      if (mem_req !== 1'b1 || misaligned !== 1'b0 || stall !== 1'b1) gap = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (gap) begin
      n_fail++;
      $display("FAIL %s busy_bus: got req/stall drop or misaligned expected steady busy", name);
    end
    n_checks++;
    if (mem_req !== 1'b0 || st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_cycle_idle: got req=%b ready=%b expected req=0 ready=1", name, mem_req, st_ready);
    end
    n_checks++;
    if (acc_q.size() != (sub ? 2 : 1)) begin
      n_fail++;
      $display("FAIL %s access_count: got %0d expected %0d", name, acc_q.size(), sub ? 2 : 1);
    end else begin
      if (sub) begin
        n_checks++;
        if (acc_q[0].we !== 1'b0 || acc_q[0].addr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s read_access: got we=%b addr=%h expected we=0 addr=%h", name, acc_q[0].we, acc_q[0].addr, exp_addr);
        end
      end
      n_checks++;
      if (acc_q[$].we !== 1'b1 || acc_q[$].addr !== exp_addr || acc_q[$].wdata !== exp_word) begin
        n_fail++;
        $display("FAIL %s write_access: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 name, acc_q[$].we, acc_q[$].addr, acc_q[$].wdata, exp_addr, exp_word);
      end
    end
  endtask

  task automatic reject_scenario(input string name, input logic [2:0] sel, input logic [31:0] a);
    acc_q.delete();
    present(sel, a, $urandom);
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (misaligned !== 1'b1 || mem_req !== 1'b0 || st_ready !== 1'b1 || st_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse: got mis=%b req=%b ready=%b done=%b expected mis=1 req=0 ready=1 done=0",
               name, misaligned, mem_req, st_ready, st_done);
    end
    @(negedge clk);
    n_checks++;
    if (misaligned !== 1'b0 || mem_req !== 1'b0 || st_ready !== 1'b1 || acc_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s after_pulse: got mis=%b req=%b ready=%b accesses=%0d expected 0/0/1/0",
               name, misaligned, mem_req, st_ready, acc_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({mem_req, mem_we, st_done, misaligned, st_ready, stall} !== 6'b000010 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got req=%b we=%b done=%b mis=%b ready=%b stall=%b addr=%h wdata=%h expected 0/0/0/0/1/0/0/0",
               mem_req, mem_we, st_done, misaligned, st_ready, stall, mem_addr, mem_wdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (st_ready !== 1'b1 || mem_req !== 1'b0 || st_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got ready=%b req=%b done=%b expected 1/0/0", st_ready, mem_req, st_done);
    end
  endtask

  task automatic test_sw_aligned();
    store_scenario("sw_zero_wait", 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0);
    n_checks++;
    if (mem_words[30'h41] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_word_value: got %h expected deadbeef", mem_words[30'h41]);
    end
  endtask

  task automatic test_sb_lane2();
    mem_words[30'h80] = 32'h1122_3344;
    store_scenario("sb_lane2", 3'b000, 32'h0000_0202, 32'h1234_56AB, 0);
    n_checks++;
    if (mem_words[30'h80] !== 32'h11AB_3344) begin
      n_fail++;
      $display("FAIL sb_word_value: got %h expected 11ab3344", mem_words[30'h80]);
    end
  endtask

  task automatic test_sh_waits();
    mem_words[30'hC0] = 32'hAAAA_BBBB;
    store_scenario("sh_upper_waits", 3'b001, 32'h0000_0302, 32'h0000_CAFE, 2);
    n_checks++;
    if (mem_words[30'hC0] !== 32'hCAFE_BBBB) begin
      n_fail++;
      $display("FAIL sh_word_value: got %h expected cafebbbb", mem_words[30'hC0]);
    end
  endtask

  task automatic test_rejects();
    reject_scenario("reject_sh_odd", 3'b001, 32'h0000_0001);
    reject_scenario("reject_sw_unaligned", 3'b010, 32'h0000_0006);
    reject_scenario("reject_illegal_sel", 3'b011, 32'h0000_0000);
    present(3'b001, 32'h0000_0003, 32'h0);
    @(negedge clk);
    n_checks++;
    if (misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_then_accept_pulse: got %b expected 1", misaligned);
    end
    store_scenario("accept_in_reject_cycle", 3'b010, 32'h0000_0400, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp2;
    int          lat1;
    int          lat2;
    bit          replay;
    wait_cycles = 1;
    exp2 = model_merge(mem_peek(32'h0000_0705), 3'b000, 32'h0000_0705, 32'h0000_0077);
    acc_q.delete();
    present(3'b010, 32'h0000_0600, 32'h1357_9BDF);
    @(negedge clk);
    present(3'b010, 32'h0000_0800, 32'hFFFF_FFFF);
    lat1 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (st_done === 1'b1) begin
        lat1 = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (lat1 != 3) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d expected 3", lat1);
    end
    n_checks++;
    if (st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_in_done: got %b expected 1", st_ready);
    end
    present(3'b000, 32'h0000_0705, 32'h0000_0077);
    @(negedge clk);
    idle_inputs();
    lat2 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (st_done === 1'b1) begin
        lat2 = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (lat2 != 5) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d expected 5", lat2);
    end
    replay = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || st_done !== 1'b0) replay = 1'b1;
    end
    n_checks++;
    if (replay || acc_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_no_replay: got accesses=%0d extra_activity=%b expected 3/0", acc_q.size(), replay);
    end else begin
      n_checks++;
      if (acc_q[0].we !== 1'b1 || acc_q[0].addr !== 32'h600 || acc_q[0].wdata !== 32'h1357_9BDF ||
          acc_q[1].we !== 1'b0 || acc_q[1].addr !== 32'h704 ||
          acc_q[2].we !== 1'b1 || acc_q[2].addr !== 32'h704 || acc_q[2].wdata !== exp2) begin
        n_fail++;
        $display("FAIL b2b_order: got %b/%h/%h %b/%h %b/%h/%h expected 1/600/13579bdf 0/704 1/704/%h",
                 acc_q[0].we, acc_q[0].addr, acc_q[0].wdata, acc_q[1].we, acc_q[1].addr,
                 acc_q[2].we, acc_q[2].addr, acc_q[2].wdata, exp2);
      end
    end
  endtask

  task automatic test_spurious_ack();
    bit activity;
    spurious = 1'b1;
    acc_q.delete();
    activity = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || st_done !== 1'b0 || st_ready !== 1'b1) activity = 1'b1;
    end
    n_checks++;
    if (activity || acc_q.size() != 0) begin
      n_fail++;
      $display("FAIL spurious_ack_idle: got activity=%b accesses=%0d expected 0/0", activity, acc_q.size());
    end
    store_scenario("store_with_spurious_ack", 3'b001, 32'h0000_0A00, 32'h0000_1234, 1);
    spurious = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit activity;
    wait_cycles = 3;
    acc_q.delete();
    present(3'b000, 32'h0000_0901, 32'h0000_00EE);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_busy: got req=%b we=%b expected 1/0", mem_req, mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, st_done, misaligned, st_ready, stall} !== 6'b000010 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_values: got req=%b we=%b done=%b mis=%b ready=%b stall=%b addr=%h wdata=%h expected 0/0/0/0/1/0/0/0",
               mem_req, mem_we, st_done, misaligned, st_ready, stall, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    activity = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || st_done !== 1'b0) activity = 1'b1;
    end
    n_checks++;
    if (activity || acc_q.size() != 0) begin
      n_fail++;
      $display("FAIL abandoned_store: got activity=%b accesses=%0d expected 0/0", activity, acc_q.size());
    end
    store_scenario("store_after_reset", 3'b000, 32'h0000_0903, 32'h0000_0055, 0);
  endtask

  task automatic test_random();
    logic [2:0]  sel;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      sel = 3'($urandom_range(0, 4));
      if (sel > 3'd2) sel = 3'($urandom_range(3, 7));
      a = 32'h0000_1000 + 32'($urandom_range(0, 31));
      if (model_reject(sel, a)) reject_scenario($sformatf("rand%0d_reject", i), sel, a);
      else store_scenario($sformatf("rand%0d_store", i), sel, a, $urandom, $urandom_range(0, 3));
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL bus_stability: got %0d changes during accesses expected 0", unstable);
    end
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_sb_lane2();
    test_sh_waits();
    test_rejects();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Write-path counterpart of the load extractor: it turns RV32I `sb`/`sh`/`sw` requests into word-wide data-memory writes. The data memory has no byte enables, so sub-word stores use a read-modify-write sequence. The unit sits between the execute stage and the data memory. It stalls the core while a store is in flight and flags misaligned or illegal stores without touching memory.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: store request from the core.
- `dm_select` in 3: funct3 of the store; 000 = sb, 001 = sh, 010 = sw, all other codes illegal.
- `addr` in 32: byte address of the store.
- `store_data` in 32: rs2 value.
- `st_ready` out 1: unit idle; a request is accepted this cycle.
- `stall` out 1: the inverse of `st_ready`.
- `st_done` out 1: one-cycle pulse; the store has been committed to memory.
- `misaligned` out 1: one-cycle pulse; the request was rejected.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: merged write word.
- `mem_rdata` in 32: read data; valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: memory completes the current access.

## Operation
- **States:** IDLE, READ, WRITE.
- **Accept:** at an edge where `st_valid && st_ready`, the unit latches `dm_select`, `addr` and `store_data`. `st_valid` is ignored while busy; requests are never queued.
- **Rejects:** these requests pulse `misaligned` for one cycle, stay in IDLE and make no memory access:
  - sh with `addr[0]=1`
  - sw with `addr[1:0]!=0`
  - any illegal `dm_select`
- **sw path:** IDLE -> WRITE. `mem_wdata = store_data`.
- **sb/sh path:** IDLE -> READ -> WRITE.
  - On the READ edge where `mem_ack=1`, the unit captures `mem_rdata` and merges into it.
  - **sb:** lane `L = addr[1:0]`; bits `[8L+7:8L]` <- `store_data[7:0]`; all other bytes are kept.
  - **sh:** bits `[16*addr[1]+15 : 16*addr[1]]` <- `store_data[15:0]`; the other half is kept.
- **Write completion:** on the WRITE edge where `mem_ack=1`, the state returns to IDLE and `st_done` pulses in the following cycle.
- **Bus drive:**
  - `mem_req` stays high for the whole of READ and WRITE.
  - `mem_we` is 1 only in WRITE.
  - `mem_addr` and `mem_wdata` are stable from the first cycle of each access until its ack.
- **Other outputs:**
  - `st_ready` = (state == IDLE); `stall` = !`st_ready`.
  - `st_done` and `misaligned` are registered and never high together.

## Timing
- **Reset values:** state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `st_done` 0, `misaligned` 0, `st_ready` 1, `stall` 0.
- **Reset mid-operation:** asserting `rst_n` low in READ or WRITE drops `mem_req` immediately, without waiting for a clock edge. The pending store is abandoned and no `st_done` is issued.
- **Memory access:** `mem_req` rises in the cycle after the accept edge. An ack in the same cycle as the request completes the access.
- **Zero-wait latency (accept edge to `st_done` high):** sw 2 cycles; sb/sh 3 cycles. Each wait cycle on `mem_ack` adds 1.
- **READ to WRITE:** the next cycle after the read ack; `mem_req` stays high and `mem_we` rises.
- **Reject timing:** `misaligned` is high in the cycle after the reject edge. `st_ready` stays high, so a new request can be accepted in that same cycle.
- **Back-to-back stores:** `st_ready` is high in the `st_done` cycle, so a new store can be accepted there.
- **Spurious ack:** `mem_ack` while `mem_req` is low is ignored.

## Test plan
- **Aligned sw, zero wait:** sw, `addr`=0x0000_0104, `store_data`=0xDEAD_BEEF, ack in the first request cycle.
  - Expect one write with `mem_addr`=0x104 and `mem_wdata`=0xDEAD_BEEF, no read, and `st_done` 2 cycles after accept.
- **sb lane 2:** sb, `addr`=0x0000_0202, `store_data`=0x1234_56AB, `mem_rdata`=0x1122_3344.
  - Expect a read then a write of 0x11AB_3344 to 0x200, and `st_done` 3 cycles after accept.
- **sh upper half with waits:** sh, `addr`=0x0000_0302, `store_data`=0x0000_CAFE, `mem_rdata`=0xAAAA_BBBB, 2 wait cycles on each ack.
  - Expect a write of 0xCAFE_BBBB, `mem_req` continuous through both accesses, and `st_done` 7 cycles after accept.
- **Rejects:** sh with `addr`=0x0000_0001, sw with `addr`=0x0000_0006, and `dm_select`=011.
  - Each gives a one-cycle `misaligned` pulse, `mem_req` stays 0 and `st_ready` stays 1.
- **Back-to-back with ignored request:** sw, then sb accepted in the sw's `st_done` cycle.
  - Expect both complete in order. `st_valid` asserted while busy is ignored and not replayed.
- **Reset mid-READ:** drive `rst_n`=0 between clock edges during READ.
  - Expect `mem_req` to fall asynchronously, all outputs at reset values, no `st_done`, and a normal store after release.
